// File: rtl/tsc_mem_pkg.sv
// Shared definitions for the multicycle CPU memory path: word width, access latency
// and the responder state encoding used by both the responder and the control unit.
package tsc_mem_pkg;

  localparam int MEM_WORD_SIZE = 16;
  localparam int MEM_LATENCY   = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2,
    RELEASE = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the datapath memory mux and the memory responder,
// plus the boot-time preload strobe.
interface mem_responder_if
  import tsc_mem_pkg::*;
#(
  parameter int WORD_SIZE = MEM_WORD_SIZE,
  parameter int ADDR_BITS = 8
);

  logic                 readM;
  logic                 writeM;
  logic [WORD_SIZE-1:0] address;
  logic [WORD_SIZE-1:0] data_in;
  logic [WORD_SIZE-1:0] data_out;
  logic                 ready;
  logic                 busy;
  logic                 protocol_err;
  logic                 load_en;
  logic [ADDR_BITS-1:0] load_addr;
  logic [WORD_SIZE-1:0] load_data;

  modport master (
    output readM, writeM, address, data_in, load_en, load_addr, load_data,
    input  data_out, ready, busy, protocol_err
  );

  modport slave (
    input  readM, writeM, address, data_in, load_en, load_addr, load_data,
    output data_out, ready, busy, protocol_err
  );

endinterface

// File: rtl/mem_array.sv
// Word storage: one write port shared by preload and request writes, and a registered
// read whose index is applied combinationally; a same-cycle write to the read index is forwarded.
module mem_array
  import tsc_mem_pkg::*;
#(
  parameter int WORD_SIZE = MEM_WORD_SIZE,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_waddr,
  input  logic [WORD_SIZE-1:0] i_wdata,
  input  logic                 i_re,
  input  logic [ADDR_BITS-1:0] i_raddr,
  output logic [WORD_SIZE-1:0] o_rdata
);

  logic [WORD_SIZE-1:0] r_mem [2**ADDR_BITS];
  logic [WORD_SIZE-1:0] r_rdata;

  // NOTE: the storage has no reset branch; contents survive reset and it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one read/write at a time, completes it after LATENCY
// cycles with a one-cycle ready pulse, then waits for the request lines to drop.
module mem_responder
  import tsc_mem_pkg::*;
#(
  parameter int WORD_SIZE = MEM_WORD_SIZE,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = MEM_LATENCY
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus
);

  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

  mem_state_e           r_state, w_next_state;
  logic [CNT_W-1:0]     r_cnt, w_cnt_next;
  logic                 r_is_write;
  logic [ADDR_BITS-1:0] r_idx;
  logic [WORD_SIZE-1:0] r_wdata;
  logic                 r_perr;

  logic                 w_accept;
  logic                 w_fire;
  logic [ADDR_BITS-1:0] w_req_idx;
  logic [ADDR_BITS-1:0] w_acc_idx;
  logic                 w_acc_write;
  logic                 w_rd_en;
  logic                 w_req_we;
  logic                 w_load_we;
  logic                 w_we;
  logic [ADDR_BITS-1:0] w_waddr;
  logic [WORD_SIZE-1:0] w_wdata;
  logic [WORD_SIZE-1:0] w_rdata;

  // Indices beyond the array depth alias modulo 2**ADDR_BITS.
  assign w_req_idx = ADDR_BITS'(bus.address);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_perr     <= 1'b0;
      r_is_write <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
      r_perr  <= w_accept & bus.readM & bus.writeM;
      if (w_accept) begin
        r_is_write <= bus.writeM;
        r_idx      <= w_req_idx;
        r_wdata    <= bus.data_in;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.readM || bus.writeM) begin
          w_accept = 1'b1;
          if (LATENCY == 1) begin
            w_next_state = RESPOND;
          end else begin
            w_next_state = ACCESS;
            w_cnt_next   = CNT_W'(LATENCY - 2);
          end
        end
      end
      ACCESS: begin
        if (r_cnt == '0) w_next_state = RESPOND;
        else             w_cnt_next   = r_cnt - 1'b1;
      end
      RESPOND: w_next_state = RELEASE;
      RELEASE: begin
        if (!bus.readM && !bus.writeM) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // w_fire marks the edge entering RESPOND; with LATENCY==1 that is the acceptance edge itself.
  assign w_fire      = !reset && (((r_state == ACCESS) && (r_cnt == '0)) || ((LATENCY == 1) && w_accept));
  assign w_acc_write = (LATENCY == 1) ? bus.writeM : r_is_write;
  assign w_acc_idx   = (LATENCY == 1) ? w_req_idx  : r_idx;
  assign w_rd_en     = w_fire && !w_acc_write;

  // With LATENCY==1 the request write is committed during RESPOND so it never contends
  // with a preload landing on the acceptance edge; no read can observe the difference.
  assign w_req_we  = (LATENCY == 1) ? ((r_state == RESPOND) && r_is_write) : (w_fire && r_is_write);
  assign w_load_we = (r_state == IDLE) && bus.load_en;
  assign w_we      = w_req_we || w_load_we;
  assign w_waddr   = w_req_we ? r_idx   : bus.load_addr;
  assign w_wdata   = w_req_we ? r_wdata : bus.load_data;

  mem_array #(
    .WORD_SIZE (WORD_SIZE),
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_rd_en),
    .i_raddr (w_acc_idx),
    .o_rdata (w_rdata)
  );

  assign bus.data_out     = w_rdata;
  assign bus.ready        = (r_state == RESPOND);
  assign bus.busy         = (r_state != IDLE);
  assign bus.protocol_err = r_perr;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a LATENCY=4 and a LATENCY=1 instance share one
// stimulus path; a word-array model predicts ready timing, read data and protocol errors.
module tb_mem_responder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_responder_if #(.WORD_SIZE(16), .ADDR_BITS(8)) ifa ();
  mem_responder_if #(.WORD_SIZE(16), .ADDR_BITS(8)) ifb ();

  mem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(4)) dut_a (
    .clk (clk), .reset (reset), .bus (ifa.slave)
  );
  mem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(1)) dut_b (
    .clk (clk), .reset (reset), .bus (ifb.slave)
  );

  // sel picks which instance receives requests/preloads and is observed.
  logic        sel = 1'b0;
  logic        t_rd = 1'b0, t_wr = 1'b0, t_ld = 1'b0;
  logic [15:0] t_addr = '0, t_din = '0, t_ldata = '0;
  logic [7:0]  t_laddr = '0;

  assign ifa.readM     = !sel && t_rd;
  assign ifa.writeM    = !sel && t_wr;
  assign ifa.load_en   = !sel && t_ld;
  assign ifa.address   = t_addr;
  assign ifa.data_in   = t_din;
  assign ifa.load_addr = t_laddr;
  assign ifa.load_data = t_ldata;
  assign ifb.readM     = sel && t_rd;
  assign ifb.writeM    = sel && t_wr;
  assign ifb.load_en   = sel && t_ld;
  assign ifb.address   = t_addr;
  assign ifb.data_in   = t_din;
  assign ifb.load_addr = t_laddr;
  assign ifb.load_data = t_ldata;

  wire        o_ready = sel ? ifb.ready        : ifa.ready;
  wire        o_busy  = sel ? ifb.busy         : ifa.busy;
  wire        o_perr  = sel ? ifb.protocol_err : ifa.protocol_err;
  wire [15:0] o_dout  = sel ? ifb.data_out     : ifa.data_out;

  logic [15:0] mem_m [2][256];
  logic [15:0] exp_dout [2];
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [15:0] data);
    t_ld = 1'b1; t_laddr = idx; t_ldata = data;
    mem_m[sel][idx] = data;
    @(negedge clk);
    t_ld = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge where the responder is idle again.
  task automatic do_req(input bit rd, input bit wr, input logic [15:0] addr, input logic [15:0] din,
                        input int hold, input bit with_load, input logic [7:0] lidx,
                        input logic [15:0] ldat);
    int d = int'(sel);
    int lat = sel ? 1 : 4;
    logic [7:0] idx = addr[7:0];
    t_rd = rd; t_wr = wr; t_addr = addr; t_din = din;
    t_ld = with_load; t_laddr = lidx; t_ldata = ldat;
    if (with_load) mem_m[d][lidx] = ldat;
    for (int n = 1; n <= lat + hold; n++) begin
      @(negedge clk);
      if (n == lat) begin
        if (wr) mem_m[d][idx] = din;
        else    exp_dout[d] = mem_m[d][idx];
      end
      check($sformatf("L%0d ready c%0d", lat, n), o_ready, (n == lat));
      check($sformatf("L%0d busy c%0d", lat, n), o_busy, 1);
      check($sformatf("L%0d perr c%0d", lat, n), o_perr, (n == 1 && rd && wr));
      check($sformatf("L%0d dout c%0d a%0h", lat, n, addr), o_dout, exp_dout[d]);
      // Everything except the held request lines is junk from here on and must be ignored.
      t_addr = 16'($urandom); t_din = 16'($urandom);
      t_ld = 1'($urandom_range(0, 1)); t_laddr = 8'($urandom); t_ldata = 16'($urandom);
    end
    t_rd = 1'b0; t_wr = 1'b0; t_ld = 1'b0;
    if (hold == 0) begin
      @(negedge clk);
      check($sformatf("L%0d release busy", lat), o_busy, 1);
      check($sformatf("L%0d release ready", lat), o_ready, 0);
    end
    @(negedge clk);
    check($sformatf("L%0d idle busy", lat), o_busy, 0);
    check($sformatf("L%0d idle ready", lat), o_ready, 0);
    check($sformatf("L%0d idle perr", lat), o_perr, 0);
    check($sformatf("L%0d idle dout", lat), o_dout, exp_dout[d]);
  endtask

  task automatic rd_req(input logic [15:0] addr);
    do_req(1'b1, 1'b0, addr, 16'h0, 1, 1'b0, 8'h0, 16'h0);
  endtask

  task automatic reset_mid_write();
    t_wr = 1'b1; t_addr = 16'h0030; t_din = 16'h5555;
    @(negedge clk);
    t_din = 16'h0000;
    @(negedge clk);
    reset = 1'b1;
    t_wr = 1'b0;
    @(negedge clk);
    exp_dout[0] = '0; exp_dout[1] = '0;
    check("rst ready", ifa.ready, 0);
    check("rst busy", ifa.busy, 0);
    check("rst perr", ifa.protocol_err, 0);
    check("rst dout", ifa.data_out, 0);
    check("rst dout b", ifb.data_out, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post-rst ready", ifa.ready, 0);
      check("post-rst busy", ifa.busy, 0);
    end
  endtask

  task automatic random_phase(input int iters);
    for (int k = 0; k < iters; k++) begin
      int op = int'($urandom_range(0, 9));
      bit rd = (op < 5) || (op == 9);
      bit wr = (op >= 5);
      logic [15:0] addr = 16'($urandom);
      bit wl = ($urandom_range(0, 3) == 0);
      logic [7:0] lidx = $urandom_range(0, 1) ? addr[7:0] : 8'($urandom);
      do_req(rd, wr, addr, 16'($urandom), int'($urandom_range(0, 3)), wl, lidx, 16'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_dout[0] = '0; exp_dout[1] = '0;
    repeat (2) @(negedge clk);
    check("reset ready a", ifa.ready, 0);
    check("reset busy a", ifa.busy, 0);
    check("reset perr a", ifa.protocol_err, 0);
    check("reset dout a", ifa.data_out, 0);
    check("reset ready b", ifb.ready, 0);
    check("reset busy b", ifb.busy, 0);
    check("reset dout b", ifb.data_out, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      for (int i = 0; i < 256; i++) preload(8'(i), 16'($urandom));
    end

    sel = 1'b0;
    @(negedge clk);
    preload(8'h05, 16'h1234);
    do_req(1'b1, 1'b0, 16'h0005, 16'h0, 3, 1'b0, 8'h0, 16'h0);
    check("tp1 read 0x05", exp_dout[0], 16'h1234);
    do_req(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1, 1'b0, 8'h0, 16'h0);
    rd_req(16'h0010);
    check("tp2 readback 0x10", o_dout, 16'hBEEF);
    do_req(1'b1, 1'b1, 16'h0020, 16'h00AA, 0, 1'b0, 8'h0, 16'h0);
    rd_req(16'h0020);
    check("tp3 readback 0x20", o_dout, 16'h00AA);
    rd_req(16'h0105);
    check("tp4 alias 0x105", o_dout, 16'h1234);
    reset_mid_write();
    rd_req(16'h0030);
    do_req(1'b1, 1'b0, 16'h0042, 16'h0, 1, 1'b1, 8'h42, 16'hCAFE);
    check("load+read same idx", o_dout, 16'hCAFE);
    random_phase(60);

    sel = 1'b1;
    @(negedge clk);
    preload(8'h05, 16'h1234);
    rd_req(16'h0005);
    check("L1 read 0x05", o_dout, 16'h1234);
    do_req(1'b0, 1'b1, 16'h0077, 16'h7777, 0, 1'b0, 8'h0, 16'h0);
    do_req(1'b1, 1'b0, 16'h0077, 16'h0, 0, 1'b0, 8'h0, 16'h0);
    check("L1 back-to-back read", o_dout, 16'h7777);
    do_req(1'b1, 1'b0, 16'h0133, 16'h0, 0, 1'b1, 8'h33, 16'h3C3C);
    check("L1 load+read forward", o_dout, 16'h3C3C);
    random_phase(60);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
